// File: rtl/tt_vchk_pkg.sv
// tt_vchk_pkg
//   Shared types for the tt_vector_checker self-test sequencer:
//   - vchk_state_t : sequencer states
//   - vchk_entry_t : one table entry {stim, exp, mask}, fields sized to
//                    VCHK_MAX_W so any IN_W/OUT_W up to that limit fits
//   - vchk_aw()    : table address width for a given depth (ceil log2)
package tt_vchk_pkg;

    localparam int unsigned VCHK_MAX_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        WAIT,
        COMPARE,
        FINISH
    } vchk_state_t;

    typedef struct packed {
        logic [VCHK_MAX_W-1:0] stim;
        logic [VCHK_MAX_W-1:0] exp;
        logic [VCHK_MAX_W-1:0] mask;
    } vchk_entry_t;

    // Smallest w with 2**w >= depth; at least 1 for depth >= 2.
    function automatic int unsigned vchk_aw(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(depth)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/tt_vchk_mem.sv
// tt_vchk_mem
//   Vector table: DEPTH x W register file, one synchronous write port and
//   one combinational read port. Storage is deliberately not reset.
//   Ports:
//     clk    in   clock
//     we     in   write enable
//     waddr  in   write index
//     wdata  in   write word
//     raddr  in   read index
//     rdata  out  read word (combinational)
module tt_vchk_mem
    import tt_vchk_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned W     = 24,
    localparam int unsigned AW    = vchk_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tt_vector_checker.sv
// tt_vector_checker
//   On-chip self-test sequencer. Holds a table of {stimulus, expected,
//   mask} vectors; on start it replays them onto dut_in, waits SETTLE
//   cycles, samples dut_out and compares under the mask, accumulating an
//   error count and the index of the first failing vector.
//   Build option: define VCHK_STOP_ON_FAIL_EN to end a run at its first
//   mismatch; otherwise every requested vector is always run.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     ena             global enable; low freezes all state
//     wr_en/wr_addr/wr_stim/wr_exp/wr_mask
//                     table write port, honoured only while idle
//     start, num_vec  run request (sampled in IDLE), vector count 0..DEPTH
//     dut_in          stimulus to the device under test
//     dut_out         response from the device under test
//     busy, done      run in progress, one-cycle end-of-run pulse
//     pass, err_count, fail_idx
//                     results of the last run
module tt_vector_checker
    import tt_vchk_pkg::*;
#(
    parameter  int unsigned IN_W   = 8,
    parameter  int unsigned OUT_W  = 8,
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned SETTLE = 1,
    localparam int unsigned AW     = vchk_aw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [IN_W-1:0]  wr_stim,
    input  logic [OUT_W-1:0] wr_exp,
    input  logic [OUT_W-1:0] wr_mask,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      err_count,
    output logic [AW-1:0]    fail_idx
);

    localparam int unsigned EW = IN_W + 2 * OUT_W;
    // Wait counter holds SETTLE-1 down to 0.
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [AW:0]   DEPTH_N   = (AW + 1)'(DEPTH);

    vchk_state_t   state;
    vchk_state_t   state_next;
    logic [AW-1:0] idx;
    logic [AW:0]   num_lat;
    logic [CW-1:0] wait_cnt;
    logic [EW-1:0] wr_word;
    logic [EW-1:0] rd_word;
    vchk_entry_t   rd_entry;
    logic          tbl_we;
    logic          mismatch;
    logic          last_vec;
    logic          unused_stim_hi;

    // Table: {stim, exp, mask}, stim in the most significant bits.
    assign wr_word = {wr_stim, wr_exp, wr_mask};
    assign tbl_we  = wr_en && ena && (state == IDLE);

    tt_vchk_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (tbl_we),
        .waddr (wr_addr),
        .wdata (wr_word),
        .raddr (idx),
        .rdata (rd_word)
    );

    always_comb begin
        rd_entry      = '0;
        rd_entry.stim = VCHK_MAX_W'(rd_word[EW-1 -: IN_W]);
        rd_entry.exp  = VCHK_MAX_W'(rd_word[2*OUT_W-1 -: OUT_W]);
        rd_entry.mask = VCHK_MAX_W'(rd_word[OUT_W-1:0]);
    end

    assign unused_stim_hi = |(rd_entry.stim >> IN_W);

    // Upper bits of exp/mask are zero, so the full-width compare is exact.
    assign mismatch = |((VCHK_MAX_W'(dut_out) ^ rd_entry.exp) & rd_entry.mask);
    assign last_vec = ((AW + 1)'(idx) + (AW + 1)'(1)) == num_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_vec == '0) ? FINISH : APPLY;
                end
            end
            APPLY: begin
                state_next = (SETTLE == 0) ? COMPARE : WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                state_next = last_vec ? FINISH : APPLY;
`ifdef VCHK_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_next = FINISH;
                end
`endif
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            num_lat   <= '0;
            wait_cnt  <= '0;
            dut_in    <= '0;
            err_count <= '0;
            fail_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat   <= (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
                        err_count <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                    end
                end
                APPLY: begin
                    dut_in   <= rd_entry.stim[IN_W-1:0];
                    wait_cnt <= WAIT_LOAD;
                end
                WAIT: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CW'(1);
                    end
                end
                COMPARE: begin
                    if (mismatch) begin
                        if (err_count == '0) begin
                            fail_idx <= idx;
                        end
                        if (err_count != DEPTH_N) begin
                            err_count <= err_count + (AW + 1)'(1);
                        end
                    end
                    idx <= idx + AW'(1);
                end
                FINISH: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    pass <= (err_count == '0);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_vector_checker.sv
module tb_tt_vector_checker;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 1;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_stim;
    logic [7:0] wr_exp;
    logic [7:0] wr_mask;
    logic       start;
    logic [4:0] num_vec;
    logic [7:0] dut_in;
    logic [7:0] dut_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] fail_idx;

    // Reference table and model state
    logic [7:0] t_stim [DEPTH];
    logic [7:0] t_exp  [DEPTH];
    logic [7:0] t_mask [DEPTH];
    logic [7:0] xor_key;
    int         m_fail_idx;
    logic [7:0] m_dut_in;

    int n_checks;
    int n_errs;

    tt_vector_checker #(
        .IN_W   (8),
        .OUT_W  (8),
        .DEPTH  (DEPTH),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_stim   (wr_stim),
        .wr_exp    (wr_exp),
        .wr_mask   (wr_mask),
        .start     (start),
        .num_vec   (num_vec),
        .dut_in    (dut_in),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_idx  (fail_idx)
    );

    // Device under self-test: a fixed XOR of its input.
    assign dut_out = dut_in ^ xor_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic write_entry(input int a, input logic [7:0] s, input logic [7:0] e, input logic [7:0] m);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_stim = s;
        wr_exp  = e;
        wr_mask = m;
        t_stim[a] = s;
        t_exp[a]  = e;
        t_mask[a] = m;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load_table();
        for (int a = 0; a < DEPTH; a++) begin
            write_entry(a, t_stim[a], t_exp[a], t_mask[a]);
        end
    endtask

    // One run: gap_at >= 0 drops ena for 5 cycles at that cycle; side_at >= 0
    // pulses start and a table write while busy; wr0 writes entry 0 on the
    // start cycle itself.
    task automatic run(input string name, input int n_req, input int gap_at,
                       input int side_at, input bit wr0);
        int n, errs, execd, base, want_cyc, cyc, gap_len;
        logic [7:0] s0, e0, m0;

        start   = 1'b1;
        num_vec = 5'(n_req);
        if (wr0) begin
            s0 = 8'($urandom);
            e0 = 8'($urandom);
            m0 = 8'($urandom);
            wr_en   = 1'b1;
            wr_addr = 4'd0;
            wr_stim = s0;
            wr_exp  = e0;
            wr_mask = m0;
            t_stim[0] = s0;
            t_exp[0]  = e0;
            t_mask[0] = m0;
        end

        n     = (n_req > DEPTH) ? DEPTH : n_req;
        errs  = 0;
        execd = 0;
        for (int v = 0; v < n; v++) begin
            execd++;
            m_dut_in = t_stim[v];
            if ((((t_stim[v] ^ xor_key) ^ t_exp[v]) & t_mask[v]) != 8'h00) begin
                if (errs == 0) m_fail_idx = v;
                errs++;
`ifdef VCHK_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        base     = (SETTLE + 2) * execd + 1;
        gap_len  = (gap_at >= 0 && gap_at < base) ? 5 : 0;
        want_cyc = base + gap_len;

        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        check({name, ".busy_rise"}, 32'(busy), 32'(1));

        cyc = 0;
        while (done !== 1'b1 && cyc < 400) begin
            if (cyc == gap_at) ena = 1'b0;
            if (gap_at >= 0 && cyc == gap_at + 5) ena = 1'b1;
            if (cyc == side_at) begin
                start   = 1'b1;
                num_vec = 5'd3;
                wr_en   = 1'b1;
                wr_addr = 4'($urandom_range(0, DEPTH - 1));
                wr_stim = 8'($urandom);
                wr_exp  = 8'($urandom);
                wr_mask = 8'hFF;
            end
            @(negedge clk);
            cyc++;
            start = 1'b0;
            wr_en = 1'b0;
        end
        ena = 1'b1;

        check({name, ".done_cycles"}, cyc, want_cyc);
        check({name, ".busy_at_done"}, 32'(busy), 32'(0));
        check({name, ".pass"}, 32'(pass), 32'(errs == 0));
        check({name, ".err_count"}, 32'(err_count), errs);
        check({name, ".fail_idx"}, 32'(fail_idx), m_fail_idx);
        check({name, ".dut_in_hold"}, 32'(dut_in), 32'(m_dut_in));
        @(negedge clk);
        check({name, ".done_pulse_width"}, 32'(done), 32'(0));
    endtask

    initial begin
        int done_seen;
        n_checks   = 0;
        n_errs     = 0;
        rst_n      = 1'b0;
        ena        = 1'b1;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_stim    = '0;
        wr_exp     = '0;
        wr_mask    = '0;
        start      = 1'b0;
        num_vec    = '0;
        xor_key    = 8'h00;
        m_fail_idx = 0;
        m_dut_in   = 8'h00;
        for (int a = 0; a < DEPTH; a++) begin
            t_stim[a] = 8'h00;
            t_exp[a]  = 8'h00;
            t_mask[a] = 8'h00;
        end

        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy), 32'(0));
        check("rst.done", 32'(done), 32'(0));
        check("rst.pass", 32'(pass), 32'(0));
        check("rst.err_count", 32'(err_count), 32'(0));
        check("rst.fail_idx", 32'(fail_idx), 32'(0));
        check("rst.dut_in", 32'(dut_in), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Loopback, all matching
        write_entry(0, 8'h11, 8'h11, 8'hFF);
        write_entry(1, 8'h22, 8'h22, 8'hFF);
        write_entry(2, 8'hAA, 8'hAA, 8'hFF);
        write_entry(3, 8'h44, 8'h44, 8'hFF);
        run("loop4", 4, -1, -1, 1'b0);

        // Single mismatch at vector 2
        write_entry(2, 8'hAA, 8'h55, 8'hFF);
        run("miss2", 4, -1, -1, 1'b0);

        // Masked compare
        write_entry(0, 8'hFF, 8'h0F, 8'h0F);
        run("mask_lo", 1, -1, -1, 1'b0);
        write_entry(0, 8'hFF, 8'h0F, 8'hF0);
        run("mask_hi", 1, -1, -1, 1'b0);
        write_entry(0, 8'hFF, 8'h00, 8'h00);
        run("mask_zero", 1, -1, -1, 1'b0);

        // Empty run
        run("nvec0", 0, -1, -1, 1'b0);

        // Clamp: full matching table, oversized request
        for (int a = 0; a < DEPTH; a++) begin
            t_stim[a] = 8'($urandom);
            t_exp[a]  = t_stim[a];
            t_mask[a] = 8'hFF;
        end
        load_table();
        run("clamp31", 31, -1, -1, 1'b0);

        // Reset in the middle of vector 2
        start   = 1'b1;
        num_vec = 5'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.busy", 32'(busy), 32'(0));
        check("midrst.dut_in", 32'(dut_in), 32'(0));
        check("midrst.err_count", 32'(err_count), 32'(0));
        m_dut_in   = 8'h00;
        m_fail_idx = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("midrst.no_done", done_seen, 0);
        load_table();
        run("after_rst", 4, -1, -1, 1'b0);

        // Writes and starts while busy are ignored; rerun identical
        t_exp[3] = t_stim[3] ^ 8'h81;
        write_entry(3, t_stim[3], t_exp[3], 8'hFF);
        run("busy_wr", 8, -1, 2, 1'b0);
        run("rerun", 8, -1, -1, 1'b0);

        // Enable held low for 5 cycles mid-run
        run("ena_gap", 8, 4, -1, 1'b0);

        // Write on the start cycle is seen by the run
        run("wr_start", 3, -1, -1, 1'b1);

        // Randomised runs
        for (int it = 0; it < 12; it++) begin
            xor_key = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
            for (int a = 0; a < DEPTH; a++) begin
                t_stim[a] = 8'($urandom);
                t_mask[a] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
                t_exp[a]  = t_stim[a] ^ xor_key ^
                            (($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h00);
            end
            load_table();
            run("rand", int'($urandom_range(0, 20)),
                ($urandom_range(0, 1) == 1) ? 4 : -1,
                ($urandom_range(0, 1) == 1) ? 2 : -1,
                1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/tt_vector_checker.md
# tt_vector_checker

On-chip self-test sequencer for the tt_um_william_carter CPU tile. It holds a small table of stimulus/expected/mask vectors and, on a start command, replays them onto the CPU's dedicated inputs. After each vector it samples the CPU's outputs and compares them under the mask, accumulating an error count and the index of the first failure. It is the parametrised, in-silicon generalisation of the cocotb harness: it runs without an external bench.

## Interface
Parameters:
- IN_W, 8, width of stimulus driven to the DUT
- OUT_W, 8, width of DUT outputs sampled
- DEPTH, 16, vector table entries (power of two, ≥2); AW = log2(DEPTH)
- SETTLE, 1, wait cycles between applying a vector and sampling (≥0)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- wr_en  in  1  table write strobe
- wr_addr  in  AW  table write index
- wr_stim  in  IN_W  stimulus word
- wr_exp  in  OUT_W  expected output word
- wr_mask  in  OUT_W  compare mask (1 = bit checked)
- start  in  1  begin run (level sampled in IDLE)
- num_vec  in  AW+1  vectors to run, 0..DEPTH; latched on start
- dut_in  out  IN_W  stimulus to DUT
- dut_out  in  OUT_W  DUT response
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pass  out  1  result of last run
- err_count  out  AW+1  mismatching vectors in last run
- fail_idx  out  AW  index of first mismatch

## Operation
- States: IDLE → APPLY → WAIT (SETTLE cycles; skipped if SETTLE=0) → COMPARE → APPLY (next) or FINISH → IDLE.
- IDLE with start=1 and ena=1: latch num_vec, clear err_count, set idx=0, busy=1, pass=0. If num_vec=0, go straight to FINISH.
- APPLY: dut_in ← stim[idx].
- COMPARE: mismatch if ((dut_out ^ exp[idx]) & mask[idx]) ≠ 0. On a mismatch, increment err_count, and capture fail_idx=idx if this is the first mismatch. Then increment idx. Go to FINISH when idx+1 = num_vec.
- FINISH: done=1 for one cycle, busy=0, pass=(err_count==0). Go to IDLE.
- dut_in holds the last vector after the run. It is cleared only by reset.
- Table writes are accepted only in IDLE. wr_en while busy is ignored.
- start while busy is ignored. A start asserted on the same cycle as a write: the write completes and the run starts; the run sees the new entry.
- A mask of all zeros always matches.
- num_vec > DEPTH is clamped to DEPTH.
- err_count cannot exceed DEPTH; no wrap.
- ena=0: no state, counter, or table change. Outputs hold.

## Timing
- Reset values:
  - state IDLE
  - dut_in, err_count, fail_idx: 0
  - busy, done, pass: 0
  - table contents undefined
- busy rises the cycle after start is sampled.
- Each vector takes SETTLE+2 cycles.
- done pulses (SETTLE+2)·num_vec + 1 cycles after busy rises. For num_vec=0 it pulses 1 cycle after busy rises.
- dut_out is sampled at the COMPARE clock edge, exactly SETTLE+1 cycles after dut_in changes.
- Reset mid-run: immediate return to the reset values. No done pulse is produced.
- pass, err_count and fail_idx are valid from the done cycle until the next start.

## Configuration
- VCHK_STOP_ON_FAIL_EN defined: the first mismatch goes straight to FINISH. err_count is then at most 1, and fail_idx equals the number of vectors executed minus one.
- VCHK_STOP_ON_FAIL_EN undefined: all num_vec vectors always run, and err_count counts every mismatch.

## Structure
- Package tt_vchk_pkg holds:
  - the state enum (IDLE, APPLY, WAIT, COMPARE, FINISH)
  - the AW derivation function
  - the vector entry struct {stim, exp, mask}
- Sub-module tt_vchk_mem: DEPTH × (IN_W+2·OUT_W) register file with one synchronous write port and one combinational read port. No reset on storage.
- Top level: the FSM, counters, and compare logic.

## Test plan
- Load 4 vectors with dut_out looped to dut_in (IN_W=OUT_W=8), exp=stim, mask=FF; start with num_vec=4 → done after 13 cycles (SETTLE=1), pass=1, err_count=0.
- Same setup but exp[2]=0x55 while stim[2]=0xAA → pass=0, err_count=1, fail_idx=2. With VCHK_STOP_ON_FAIL_EN the run also stops after vector 2 (done after 10 cycles).
- Vector with exp=0x0F, dut_out=0xFF, mask=0x0F → counted as a match. Same vector with mask=0xF0 → mismatch.
- num_vec=0 → done 1 cycle after busy rises, pass=1. num_vec=31 with DEPTH=16 → 16 vectors run.
- Deassert rst_n during vector 2 → busy=0, dut_in=0 immediately, no done pulse. A fresh start afterwards runs normally.
- wr_en during a run → table unchanged; a rerun gives identical results. Holding ena low for 5 cycles mid-run → done is delayed by exactly 5 cycles.
